// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals between the arbiter and its three neighbours: the instruction-fetch
// requester (i_*), the EX/MEM data requester (d_*), and the shared memory port (mem_*).
//  slave  : arbiter view. It takes the requests and mem_rdata/mem_resp, and drives the
//           responses and the memory command.
//  master : environment view, the mirror image of slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [MASK_W-1:0] d_wmask;
  logic [DATA_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_byte_enable;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_addr, mem_wdata, mem_byte_enable
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_addr, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and the data side (D).
// Arbitration happens once per transaction, and ties go round-robin. Memory commands
// are registered. Each response goes back to the side that owns the port, in the same
// cycle as mem_resp.
// Ports:
//  clk      rising-edge clock
//  rst      asynchronous active-low reset
//  bus      request / response / memory-command bundle (slave view)
//  busy     port is serving a transaction
//  owner_d  port is serving the D side
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4,
  parameter bit PRIO_D = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic                 busy,
  output logic                 owner_d
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t            state;
  state_t            state_next;
  logic              last_d;      // side that completed most recently: 1 = D, 0 = I
  logic              req_i;
  logic              req_d;
  logic              grant_i;
  logic              grant_d;
  logic              done;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [MASK_W-1:0] mem_be_q;

  assign req_i = bus.i_read;
  assign req_d = bus.d_read | bus.d_write;
  assign done  = (state != IDLE) && bus.mem_resp;

  // On a response cycle only the other side may be granted. The owner's request is
  // still asserted then, and granting it again would issue a duplicate transaction.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (req_i && req_d) begin
          if (last_d) grant_i = 1'b1;
          else        grant_d = 1'b1;
        end else if (req_i) begin
          grant_i = 1'b1;
        end else if (req_d) begin
          grant_d = 1'b1;
        end
      end
      SERVE_I: if (bus.mem_resp && req_d) grant_d = 1'b1;
      SERVE_D: if (bus.mem_resp && req_i) grant_i = 1'b1;
      default: state_next = IDLE;
    endcase
    if (grant_i)      state_next = SERVE_I;
    else if (grant_d) state_next = SERVE_D;
    else if (done)    state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_d      <= !PRIO_D;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state <= state_next;
      if (done) last_d <= (state == SERVE_D);
      if (grant_i) begin
        mem_read_q  <= 1'b1;
        mem_write_q <= 1'b0;
        mem_addr_q  <= bus.i_addr;
        mem_wdata_q <= '0;
        mem_be_q    <= '1;
      end else if (grant_d) begin
        // A write takes precedence when both d_read and d_write are asserted.
        mem_read_q  <= !bus.d_write;
        mem_write_q <= bus.d_write;
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
        mem_be_q    <= bus.d_write ? bus.d_wmask : '1;
      end else if (done) begin
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
      end
    end
  end

  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.mem_byte_enable = mem_be_q;

  assign bus.i_resp  = (state == SERVE_I) && bus.mem_resp;
  assign bus.d_resp  = (state == SERVE_D) && bus.mem_resp;
  assign bus.i_rdata = (state == SERVE_I) ? bus.mem_rdata : '0;
  assign bus.d_rdata = (state == SERVE_D) ? bus.mem_rdata : '0;

  assign busy    = (state != IDLE);
  assign owner_d = (state == SERVE_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic owner_d;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MASK_W(4)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(4), .PRIO_D(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .owner_d(owner_d)
  );

  typedef struct {
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dm;
    logic [31:0] ird;
    logic [31:0] drd;
    int          hold;
  } vec_t;

  typedef struct {
    bit          side_d;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   tests = 0;
  int   fails = 0;
  bit   model_last_d = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t exp_i(input vec_t v);
    exp_t e;
    e.side_d = 1'b0; e.rd = 1'b1; e.wr = 1'b0; e.addr = v.ia;
    e.wdata = '0; e.be = 4'hF; e.rdata = v.ird;
    return e;
  endfunction

  function automatic exp_t exp_d(input vec_t v);
    exp_t e;
    e.side_d = 1'b1; e.rd = !v.dw; e.wr = v.dw; e.addr = v.da;
    e.wdata = v.dwd; e.be = v.dw ? v.dm : 4'hF; e.rdata = v.drd;
    return e;
  endfunction

  task automatic drive(input vec_t v);
    bus.i_read  = v.ir;  bus.i_addr  = v.ia;
    bus.d_read  = v.dr;  bus.d_write = v.dw;
    bus.d_addr  = v.da;  bus.d_wdata = v.dwd; bus.d_wmask = v.dm;
  endtask

  // Bounded wait for a memory command; returns the number of cycles it took.
  task automatic wait_cmd(output int waited, output bit ok);
    waited = 0;
    #1;
    while (!(bus.mem_read || bus.mem_write) && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    ok = bus.mem_read || bus.mem_write;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL cmd_timeout: got no command expected command at %0t", $time);
    end
  endtask

  task automatic serve_one(input bit first, input int hold, input bit drop_self,
                           input bit drop_other, input bit perturb);
    int   waited;
    bit   ok;
    exp_t e;
    wait_cmd(waited, ok);
    if (!ok) return;
    check("cmd_latency", waited, first ? 1 : 0);
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL sb_underflow: got command expected none at %0t", $time);
      return;
    end
    e = sb.pop_front();
    check("mem_read",  bus.mem_read,  e.rd);
    check("mem_write", bus.mem_write, e.wr);
    check("mem_addr",  bus.mem_addr,  e.addr);
    check("mem_wdata", bus.mem_wdata, e.wdata);
    check("mem_be",    bus.mem_byte_enable, e.be);
    check("owner_d",   owner_d, e.side_d);
    check("busy",      busy, 1'b1);
    if (drop_other) begin
      if (e.side_d) bus.i_read = 1'b0;
      else begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
    end
    if (perturb) begin
      bus.d_addr  = bus.d_addr + 32'h4;
      bus.d_wdata = ~bus.d_wdata;
      bus.d_write = 1'b1;
    end
    repeat (hold) begin
      @(negedge clk); #1;
      check("hold_addr",  bus.mem_addr, e.addr);
      check("hold_read",  bus.mem_read, e.rd);
      check("hold_write", bus.mem_write, e.wr);
    end
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = e.rdata;
    #1;
    check("i_resp",  bus.i_resp, !e.side_d);
    check("d_resp",  bus.d_resp, e.side_d);
    check("own_rdata",   e.side_d ? bus.d_rdata : bus.i_rdata, e.rdata);
    check("other_rdata", e.side_d ? bus.i_rdata : bus.d_rdata, 32'h0);
    @(negedge clk);
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = $urandom;
    if (drop_self) begin
      if (e.side_d) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
      else bus.i_read = 1'b0;
    end
    model_last_d = e.side_d;
  endtask

  initial begin
    vec_t v;
    int   n;
    int   waited;
    bit   ok;
    bit   s;

    bus.i_read = 0; bus.i_addr = 0; bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.d_wmask = 0;
    bus.mem_rdata = 32'hCAFE_F00D; bus.mem_resp = 0;

    //            ir ia          dr dw da          dwd           dm       ird           drd           hold
    vecs[0] = '{1, 32'h200, 0, 1, 32'h100, 32'hA5A5_0F0F, 4'b0011, 32'h1111_2222, 32'h3333_4444, 1};
    vecs[1] = '{1, 32'h060, 0, 0, 32'h0,   32'h0,         4'h0,    32'h0000_0013, 32'h0,         0};
    vecs[2] = '{0, 32'h0,   1, 1, 32'h120, 32'hDEAD_BEEF, 4'b1100, 32'h0,         32'h0BAD_F00D, 2};
    vecs[3] = '{0, 32'h0,   1, 0, 32'h044, 32'h1234_5678, 4'b0101, 32'h0,         32'h7777_8888, 0};
    vecs[4] = '{1, 32'h208, 1, 0, 32'h148, 32'h0,         4'h0,    32'h5555_6666, 32'h9999_AAAA, 1};
    vecs[5] = '{1, 32'h20C, 0, 0, 32'h0,   32'h0,         4'h0,    32'hBBBB_CCCC, 32'h0,         0};

    // Reset state
    #1;
    check("rst_mem_read",  bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_mem_addr",  bus.mem_addr, 32'h0);
    check("rst_busy",      busy, 1'b0);
    check("rst_owner_d",   owner_d, 1'b0);
    @(negedge clk); rst = 1'b1;

    // Reset asserted in the middle of a D write abandons it with no response
    @(negedge clk);
    bus.d_write = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'h0F0F_0F0F; bus.d_wmask = 4'hF;
    wait_cmd(waited, ok);
    check("mid_owner_d", owner_d, 1'b1);
    rst = 1'b0; bus.mem_resp = 1'b1;
    #1;
    check("mid_rst_read",  bus.mem_read, 1'b0);
    check("mid_rst_write", bus.mem_write, 1'b0);
    check("mid_rst_addr",  bus.mem_addr, 32'h0);
    check("mid_rst_wdata", bus.mem_wdata, 32'h0);
    check("mid_rst_be",    bus.mem_byte_enable, 4'h0);
    check("mid_rst_busy",  busy, 1'b0);
    check("mid_rst_dresp", bus.d_resp, 1'b0);
    @(negedge clk);
    bus.mem_resp = 1'b0; bus.d_write = 1'b0; rst = 1'b1;
    model_last_d = 1'b0;
    @(negedge clk); #1;
    check("post_rst_busy",  busy, 1'b0);
    check("post_rst_write", bus.mem_write, 1'b0);

    // Table-driven transactions
    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      drive(v);
      n = 0;
      if (v.ir && (v.dr || v.dw)) begin
        if (model_last_d) begin sb.push_back(exp_i(v)); sb.push_back(exp_d(v)); end
        else              begin sb.push_back(exp_d(v)); sb.push_back(exp_i(v)); end
        n = 2;
      end else if (v.ir) begin
        sb.push_back(exp_i(v)); n = 1;
      end else if (v.dr || v.dw) begin
        sb.push_back(exp_d(v)); n = 1;
      end
      for (int j = 0; j < n; j++) serve_one(j == 0, v.hold, 1'b1, 1'b0, 1'b0);
      #1;
      check("idle_busy",  busy, 1'b0);
      check("idle_read",  bus.mem_read, 1'b0);
      check("idle_write", bus.mem_write, 1'b0);
    end

    // Both sides held across six transactions: grants must alternate
    v = '{1, 32'h400, 1, 0, 32'h500, 32'h0, 4'h0, 32'h0, 32'h0, 0};
    drive(v);
    s = !model_last_d;
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      e = s ? exp_d(v) : exp_i(v);
      e.rdata = 32'h1000 + k;
      sb.push_back(e);
      s = !s;
    end
    for (int k = 0; k < 6; k++) serve_one(k == 0, k % 2, k == 5, k == 5, 1'b0);
    #1;
    check("fair_idle_busy", busy, 1'b0);

    // Command held stable while the D inputs change mid-flight
    v = '{0, 32'h0, 1, 0, 32'h300, 32'h55, 4'h0, 32'h0, 32'hFEED_0300, 3};
    drive(v);
    sb.push_back(exp_d(v));
    serve_one(1'b1, 3, 1'b1, 1'b0, 1'b1);

    // mem_resp while idle produces no response
    bus.mem_resp = 1'b1; bus.mem_rdata = 32'h7E57_7E57;
    #1;
    check("idle_i_resp",  bus.i_resp, 1'b0);
    check("idle_d_resp",  bus.d_resp, 1'b0);
    check("idle_i_rdata", bus.i_rdata, 32'h0);
    check("idle_d_rdata", bus.d_rdata, 32'h0);
    @(negedge clk);
    bus.mem_resp = 1'b0;
    #1;
    check("final_busy", busy, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
